// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: turns core byte/half/word loads and stores into single-beat full-word bridge handshakes
module mem_access_ctrl #(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] S_ARWADDR,
  output logic        S_AWVALID,
  input  logic        S_AWREADY,
  output logic [31:0] S_WDATA,
  output logic        S_WVALID,
  input  logic        S_WREADY,
  input  logic        S_BVALID,
  output logic        S_BREADY,
  output logic        S_ARVALID,
  input  logic        S_ARREADY,
  input  logic [31:0] S_RDATA,
  input  logic        S_RVALID,
  output logic        S_RREADY
);
  localparam logic [2:0] IDLE = 3'd0, RD_A = 3'd1, RD_D = 3'd2, WR_AW = 3'd3, WR_B = 3'd4, RESP = 3'd5;
  logic [2:0]  state;
  logic [31:0] addr_q, wdata_q, mask, ext, merged;
  logic [1:0]  size_q, blane;
  logic        we_q, sgn_q, hlane, bad;
  logic [4:0]  sh;
  logic [15:0] field;
  assign req_ready = state == IDLE;
  assign S_ARWADDR = {addr_q[31:2], 2'b00};
  // Lane selection, load extension, sub-word merge and request legality
  always_comb begin
    blane  = BIG_ENDIAN ? 2'd3 - addr_q[1:0] : addr_q[1:0];
    hlane  = BIG_ENDIAN ? ~addr_q[1] : addr_q[1];
    sh     = size_q == 2'd0 ? {blane, 3'b000} : {hlane, 4'b0000};
    mask   = (size_q == 2'd0 ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    field  = 16'(S_RDATA >> sh);
    ext    = size_q == 2'd2 ? S_RDATA :
             size_q == 2'd1 ? {{16{sgn_q & field[15]}}, field} :
                              {{24{sgn_q & field[7]}}, field[7:0]};
    merged = (S_RDATA & ~mask) | ((wdata_q << sh) & mask);
    bad    = req_size == 2'd3 || (req_size == 2'd1 && req_addr[0]) ||
             (req_size == 2'd2 && req_addr[1:0] != 2'b00);
  end
  // Transaction sequencer with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      we_q       <= 1'b0;
      sgn_q      <= 1'b0;
      S_WDATA    <= '0;
      S_ARVALID  <= 1'b0;
      S_RREADY   <= 1'b0;
      S_AWVALID  <= 1'b0;
      S_WVALID   <= 1'b0;
      S_BREADY   <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          addr_q  <= req_addr;
          size_q  <= req_size;
          we_q    <= req_we;
          sgn_q   <= req_signed;
          wdata_q <= req_wdata;
          if (bad) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else if (req_we && req_size == 2'd2) begin
            state     <= WR_AW;
            S_WDATA   <= req_wdata;
            S_AWVALID <= 1'b1;
            S_WVALID  <= 1'b1;
          end else begin
            state     <= RD_A;
            S_ARVALID <= 1'b1;
          end
        end
        RD_A: if (S_ARREADY) begin
          S_ARVALID <= 1'b0;
          S_RREADY  <= 1'b1;
          state     <= RD_D;
        end
        RD_D: if (S_RVALID) begin
          S_RREADY <= 1'b0;
          if (we_q) begin
            S_WDATA   <= merged;
            S_AWVALID <= 1'b1;
            S_WVALID  <= 1'b1;
            state     <= WR_AW;
          end else begin
            resp_rdata <= ext;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        WR_AW: begin
          if (S_AWREADY) S_AWVALID <= 1'b0;
          if (S_WREADY) S_WVALID <= 1'b0;
          if ((!S_AWVALID || S_AWREADY) && (!S_WVALID || S_WREADY)) begin
            S_BREADY <= 1'b1;
            state    <= WR_B;
          end
        end
        WR_B: if (S_BVALID) begin
          S_BREADY   <= 1'b0;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and randomized checks of mem_access_ctrl against a byte-level memory model
module tb_mem_access_ctrl;
  localparam logic [31:0] BASE = 32'h2000_0000;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata, S_ARWADDR, S_WDATA, S_RDATA;
  logic        S_AWVALID, S_WVALID, S_BREADY, S_ARVALID, S_RREADY;
  logic        S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RVALID;
  logic        m_awready = 0, m_wready = 0, m_bvalid = 0, m_arready = 0, m_rvalid = 0;
  logic [31:0] m_rdata = '0, a_rdata = '0;
  logic        a_awready = 0, a_wready = 0, a_bvalid = 0, a_arready = 0, a_rvalid = 0;
  bit          auto_en = 1'b0;
  int          rdy_pct = 100;
  int          vectors = 0, miscompares = 0;
  int          proto_err = 0, bus_act = 0, ar_hs = 0, w_hs = 0;
  logic [31:0] last_wdata = '0, p_addr = '0, p_wdata = '0;
  logic        any, p_any = 0, p_arv = 0, p_arr = 0, p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0;
  logic [31:0] bus_mem [int unsigned];
  logic [7:0]  ref_mem [int unsigned];

  assign S_ARREADY = auto_en ? a_arready : m_arready;
  assign S_RVALID  = auto_en ? a_rvalid  : m_rvalid;
  assign S_RDATA   = auto_en ? a_rdata   : m_rdata;
  assign S_AWREADY = auto_en ? a_awready : m_awready;
  assign S_WREADY  = auto_en ? a_wready  : m_wready;
  assign S_BVALID  = auto_en ? a_bvalid  : m_bvalid;

  mem_access_ctrl #(.BIG_ENDIAN(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .S_ARWADDR(S_ARWADDR),
    .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY), .S_WDATA(S_WDATA), .S_WVALID(S_WVALID),
    .S_WREADY(S_WREADY), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY), .S_ARVALID(S_ARVALID),
    .S_ARREADY(S_ARREADY), .S_RDATA(S_RDATA), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
  );

  always #5 clk = ~clk;

  // Randomly stalling bridge model backed by a word memory
  always @(posedge clk) begin
    #2;
    a_arready = S_ARVALID && int'($urandom_range(0, 99)) < rdy_pct;
    a_rvalid  = S_RREADY  && int'($urandom_range(0, 99)) < rdy_pct;
    a_awready = S_AWVALID && int'($urandom_range(0, 99)) < rdy_pct;
    a_wready  = S_WVALID  && int'($urandom_range(0, 99)) < rdy_pct;
    a_bvalid  = S_BREADY  && int'($urandom_range(0, 99)) < rdy_pct;
    a_rdata   = bus_mem.exists(S_ARWADDR >> 2) ? bus_mem[S_ARWADDR >> 2] : 32'h0;
  end

  // Bus monitor: exclusivity, alignment, payload stability, valid hold, handshake counts
  always @(negedge clk) begin
    if (!rst_n) begin
      p_any = 0; p_arv = 0; p_awv = 0; p_wv = 0;
    end else begin
      any = S_ARVALID | S_RREADY | S_AWVALID | S_WVALID | S_BREADY;
      if ((S_ARVALID || S_RREADY) && (S_AWVALID || S_WVALID || S_BREADY)) proto_err++;
      if (any && S_ARWADDR[1:0] != 2'b00) proto_err++;
      if (p_any && any && S_ARWADDR != p_addr) proto_err++;
      if (p_wv && S_WVALID && S_WDATA != p_wdata) proto_err++;
      if ((p_arv && !p_arr && !S_ARVALID) || (p_awv && !p_awr && !S_AWVALID) || (p_wv && !p_wr && !S_WVALID)) proto_err++;
      if (S_ARVALID || S_AWVALID || S_WVALID) bus_act++;
      if (S_ARVALID && S_ARREADY) ar_hs++;
      if (S_WVALID && S_WREADY) begin
        w_hs++;
        last_wdata = S_WDATA;
        bus_mem[S_ARWADDR >> 2] = S_WDATA;
      end
      p_any = any; p_addr = S_ARWADDR; p_wdata = S_WDATA;
      p_arv = S_ARVALID; p_arr = S_ARREADY; p_awv = S_AWVALID; p_awr = S_AWREADY; p_wv = S_WVALID; p_wr = S_WREADY;
    end
  end

  task automatic next;
    @(posedge clk);
    #2;
  endtask

  task automatic set_word(input logic [31:0] addr, input logic [31:0] v);
    bus_mem[addr >> 2] = v;
    for (int i = 0; i < 4; i++) ref_mem[addr + i] = 8'(v >> (8 * i));
  endtask

  function automatic logic model_bad(input logic [1:0] size, input logic [31:0] addr);
    return size == 2'd3 || (addr % (32'd1 << size)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn, input logic [31:0] addr);
    int n = 1 << size;
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = v | ({24'b0, ref_mem[addr + i]} << (8 * i));
    if (sgn && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic model_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    for (int i = 0; i < (1 << size); i++) ref_mem[addr + i] = 8'(wdata >> (8 * i));
  endtask

  task automatic run_txn(input logic we, input logic [1:0] size, input logic sgn, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic got_v, output logic [31:0] got_d,
                         output logic got_e, output int cyc, output logic pulse_rdy, output logic after_ok);
    bus_act = 0; ar_hs = 0; w_hs = 0;
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    next();
    req_valid = 1'b0;
    cyc = 1;
    while (!resp_valid && cyc < 60) begin
      next();
      cyc++;
    end
    got_v = resp_valid; got_d = resp_rdata; got_e = resp_err; pulse_rdy = req_ready;
    next();
    after_ok = !resp_valid && req_ready;
  endtask

  task automatic test_reset;
    next();
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
    vectors++; if ({S_ARVALID, S_RREADY, S_AWVALID, S_WVALID, S_BREADY} !== 5'b0) begin miscompares++; $display("FAIL rst_handshakes: got %b want 00000", {S_ARVALID, S_RREADY, S_AWVALID, S_WVALID, S_BREADY}); end
    vectors++; if ({resp_valid, resp_err, resp_rdata, S_ARWADDR, S_WDATA} !== 98'b0) begin miscompares++; $display("FAIL rst_data: got %b %b %h %h %h want zeros", resp_valid, resp_err, resp_rdata, S_ARWADDR, S_WDATA); end
    rst_n = 1'b1;
    next();
  endtask

  task automatic test_word_load;
    auto_en = 1'b0;
    req_we = 0; req_size = 2'd2; req_signed = 0; req_addr = 32'h1000_0008; req_valid = 1'b1;
    next();
    req_valid = 1'b0;
    vectors++; if (S_ARVALID !== 1'b1) begin miscompares++; $display("FAIL wl_arvalid_c1: got %b want 1", S_ARVALID); end
    vectors++; if (S_ARWADDR !== 32'h1000_0008) begin miscompares++; $display("FAIL wl_addr: got %h want 10000008", S_ARWADDR); end
    m_arready = 1'b1;
    next();
    m_arready = 1'b0;
    vectors++; if ({S_ARVALID, S_RREADY} !== 2'b01) begin miscompares++; $display("FAIL wl_rready_c2: got %b want 01", {S_ARVALID, S_RREADY}); end
    m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF;
    next();
    m_rvalid = 1'b0;
    vectors++; if ({resp_valid, resp_err} !== 2'b10) begin miscompares++; $display("FAIL wl_resp_c3: got %b want 10", {resp_valid, resp_err}); end
    vectors++; if (resp_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL wl_rdata: got %h want deadbeef", resp_rdata); end
    next();
  endtask

  task automatic test_byte_load;
    logic v, e, pr, ok;
    logic [31:0] d;
    int c;
    auto_en = 1'b1; rdy_pct = 100;
    set_word(BASE + 32'h4, 32'h80AA_BBCC);
    run_txn(0, 2'd0, 1, BASE + 32'h7, 32'h0, v, d, e, c, pr, ok);
    vectors++; if ({v, e, d} !== {2'b10, 32'hFFFF_FF80}) begin miscompares++; $display("FAIL lb_signed: got v%b e%b %h want v1 e0 ffffff80", v, e, d); end
    vectors++; if (c !== 3) begin miscompares++; $display("FAIL lb_latency: got %0d want 3", c); end
    run_txn(0, 2'd0, 0, BASE + 32'h7, 32'h0, v, d, e, c, pr, ok);
    vectors++; if ({v, e, d} !== {2'b10, 32'h0000_0080}) begin miscompares++; $display("FAIL lbu: got v%b e%b %h want v1 e0 00000080", v, e, d); end
    run_txn(0, 2'd1, 1, BASE + 32'h6, 32'h0, v, d, e, c, pr, ok);
    vectors++; if ({v, e, d} !== {2'b10, 32'hFFFF_80AA}) begin miscompares++; $display("FAIL lh_signed: got v%b e%b %h want v1 e0 ffff80aa", v, e, d); end
    run_txn(0, 2'd1, 0, BASE + 32'h4, 32'h0, v, d, e, c, pr, ok);
    vectors++; if ({v, e, d} !== {2'b10, 32'h0000_BBCC}) begin miscompares++; $display("FAIL lhu_low: got v%b e%b %h want v1 e0 0000bbcc", v, e, d); end
  endtask

  task automatic test_word_store_skew;
    auto_en = 1'b0;
    req_we = 1; req_size = 2'd2; req_signed = 0; req_addr = 32'h3000_0020; req_wdata = 32'hCAFE_F00D; req_valid = 1'b1;
    next();
    req_valid = 1'b0;
    vectors++; if ({S_AWVALID, S_WVALID, S_WDATA} !== {2'b11, 32'hCAFE_F00D}) begin miscompares++; $display("FAIL ws_c1: got aw%b w%b %h want aw1 w1 cafef00d", S_AWVALID, S_WVALID, S_WDATA); end
    m_awready = 1'b1;
    next();
    m_awready = 1'b0;
    vectors++; if ({S_AWVALID, S_WVALID} !== 2'b01) begin miscompares++; $display("FAIL ws_c2: got aw%b w%b want aw0 w1", S_AWVALID, S_WVALID); end
    next();
    vectors++; if ({S_WVALID, S_WDATA, S_BREADY} !== {1'b1, 32'hCAFE_F00D, 1'b0}) begin miscompares++; $display("FAIL ws_c3: got w%b %h b%b want w1 cafef00d b0", S_WVALID, S_WDATA, S_BREADY); end
    next();
    vectors++; if ({S_WVALID, S_WDATA} !== {1'b1, 32'hCAFE_F00D}) begin miscompares++; $display("FAIL ws_c4: got w%b %h want w1 cafef00d", S_WVALID, S_WDATA); end
    m_wready = 1'b1;
    next();
    m_wready = 1'b0;
    vectors++; if ({S_WVALID, S_BREADY, resp_valid} !== 3'b010) begin miscompares++; $display("FAIL ws_c5: got w%b b%b r%b want w0 b1 r0", S_WVALID, S_BREADY, resp_valid); end
    next();
    m_bvalid = 1'b1;
    next();
    m_bvalid = 1'b0;
    vectors++; if ({resp_valid, resp_err, resp_rdata, S_BREADY} !== {2'b10, 32'h0, 1'b0}) begin miscompares++; $display("FAIL ws_resp_c7: got v%b e%b %h b%b want v1 e0 0 b0", resp_valid, resp_err, resp_rdata, S_BREADY); end
    next();
  endtask

  task automatic test_byte_store_rmw;
    logic v, e, pr, ok;
    logic [31:0] d;
    int c;
    auto_en = 1'b1; rdy_pct = 100;
    set_word(BASE + 32'h10, 32'h1122_3344);
    run_txn(1, 2'd0, 0, BASE + 32'h11, 32'h0000_0055, v, d, e, c, pr, ok);
    model_store(2'd0, BASE + 32'h11, 32'h0000_0055);
    vectors++; if ({v, e, d} !== {2'b10, 32'h0}) begin miscompares++; $display("FAIL sb_resp: got v%b e%b %h want v1 e0 0", v, e, d); end
    vectors++; if (c !== 5) begin miscompares++; $display("FAIL sb_latency: got %0d want 5", c); end
    vectors++; if ({ar_hs, w_hs} !== {32'd1, 32'd1}) begin miscompares++; $display("FAIL sb_beats: got ar%0d w%0d want ar1 w1", ar_hs, w_hs); end
    vectors++; if (last_wdata !== 32'h1122_5544) begin miscompares++; $display("FAIL sb_wdata: got %h want 11225544", last_wdata); end
    run_txn(1, 2'd1, 0, BASE + 32'h12, 32'hFFFF_A1B2, v, d, e, c, pr, ok);
    model_store(2'd1, BASE + 32'h12, 32'hFFFF_A1B2);
    vectors++; if (last_wdata !== 32'hA1B2_5544) begin miscompares++; $display("FAIL sh_wdata: got %h want a1b25544", last_wdata); end
  endtask

  task automatic test_misaligned;
    logic v, e, pr, ok;
    logic [31:0] d;
    int c;
    logic [34:0] cases [3] = '{{1'b0, 2'd2, BASE + 32'h2}, {1'b1, 2'd1, BASE + 32'h1}, {1'b0, 2'd3, BASE}};
    auto_en = 1'b1; rdy_pct = 100;
    foreach (cases[k]) begin
      run_txn(cases[k][34], cases[k][33:32], 0, cases[k][31:0], 32'h1234_5678, v, d, e, c, pr, ok);
      vectors++; if ({v, e, d} !== {2'b11, 32'h0}) begin miscompares++; $display("FAIL mis%0d_resp: got v%b e%b %h want v1 e1 0", k, v, e, d); end
      vectors++; if (c !== 1) begin miscompares++; $display("FAIL mis%0d_latency: got %0d want 1", k, c); end
      vectors++; if (bus_act !== 0) begin miscompares++; $display("FAIL mis%0d_bus: got %0d valid cycles want 0", k, bus_act); end
    end
  endtask

  task automatic test_back_to_back;
    logic v, e, pr, ok;
    logic [31:0] d;
    int c;
    auto_en = 1'b1; rdy_pct = 100;
    run_txn(1, 2'd2, 0, BASE + 32'h8, 32'h5A5A_0F0F, v, d, e, c, pr, ok);
    model_store(2'd2, BASE + 32'h8, 32'h5A5A_0F0F);
    vectors++; if (c !== 3) begin miscompares++; $display("FAIL b2b_store_latency: got %0d want 3", c); end
    vectors++; if ({pr, ok} !== 2'b01) begin miscompares++; $display("FAIL b2b_ready: got pulse_rdy%b after_ok%b want 0 1", pr, ok); end
    run_txn(0, 2'd2, 0, BASE + 32'h8, 32'h0, v, d, e, c, pr, ok);
    vectors++; if ({v, e, d} !== {2'b10, 32'h5A5A_0F0F}) begin miscompares++; $display("FAIL b2b_load: got v%b e%b %h want v1 e0 5a5a0f0f", v, e, d); end
  endtask

  task automatic test_reset_mid_read;
    logic v, e, pr, ok, seen;
    logic [31:0] d;
    int c;
    auto_en = 1'b0; seen = 1'b0;
    req_we = 0; req_size = 2'd2; req_signed = 0; req_addr = BASE + 32'hC; req_valid = 1'b1;
    next();
    req_valid = 1'b0;
    m_arready = 1'b1;
    next();
    m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0BAD_0BAD;
    vectors++; if (S_RREADY !== 1'b1) begin miscompares++; $display("FAIL rmr_in_rd_d: got %b want 1", S_RREADY); end
    #1 rst_n = 1'b0;
    #1;
    vectors++; if ({req_ready, S_RREADY, S_ARVALID, resp_valid, S_ARWADDR} !== {1'b1, 35'b0}) begin miscompares++; $display("FAIL rmr_outputs: got rdy%b rr%b arv%b rv%b %h want 1 0 0 0 0", req_ready, S_RREADY, S_ARVALID, resp_valid, S_ARWADDR); end
    for (int i = 0; i < 3; i++) begin
      next();
      seen = seen | resp_valid;
    end
    rst_n = 1'b1; m_rvalid = 1'b0;
    next();
    seen = seen | resp_valid;
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL rmr_no_resp: got %b want 0", seen); end
    auto_en = 1'b1; rdy_pct = 100;
    run_txn(0, 2'd2, 0, BASE + 32'hC, 32'h0, v, d, e, c, pr, ok);
    vectors++; if ({v, e, d, c} !== {2'b10, model_load(2'd2, 0, BASE + 32'hC), 32'd3}) begin miscompares++; $display("FAIL rmr_clean: got v%b e%b %h c%0d want v1 e0 %h c3", v, e, d, c, model_load(2'd2, 0, BASE + 32'hC)); end
  endtask

  task automatic test_random;
    logic v, e, pr, ok, we, sgn, bad;
    logic [31:0] d, exp, addr, wd;
    logic [1:0] sz;
    int c;
    auto_en = 1'b1; rdy_pct = 60;
    for (int n = 0; n < 200; n++) begin
      we = 1'($urandom_range(0, 1));
      sz = $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
      sgn = 1'($urandom_range(0, 1));
      addr = BASE + $urandom_range(0, 63);
      wd = $urandom;
      bad = model_bad(sz, addr);
      exp = (bad || we) ? 32'h0 : model_load(sz, sgn, addr);
      run_txn(we, sz, sgn, addr, wd, v, d, e, c, pr, ok);
      if (!bad && we) model_store(sz, addr, wd);
      vectors++; if ({v, e, d} !== {1'b1, bad, exp}) begin miscompares++; $display("FAIL rnd%0d we%b sz%0d a%h: got v%b e%b %h want v1 e%b %h", n, we, sz, addr, v, e, d, bad, exp); end
      vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL rnd%0d_pulse: got after_ok %b want 1", n, ok); end
      if (bad) begin
        vectors++; if (bus_act !== 0) begin miscompares++; $display("FAIL rnd%0d_errbus: got %0d want 0", n, bus_act); end
      end
    end
    for (int w = 0; w < 16; w++) begin
      exp = model_load(2'd2, 0, BASE + 4 * w);
      vectors++; if (bus_mem[(BASE >> 2) + w] !== exp) begin miscompares++; $display("FAIL mem_word%0d: got %h want %h", w, bus_mem[(BASE >> 2) + w], exp); end
    end
  endtask

  task automatic test_protocol;
    vectors++; if (proto_err !== 0) begin miscompares++; $display("FAIL protocol: got %0d violations want 0", proto_err); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int w = 0; w < 16; w++) set_word(BASE + 4 * w, $urandom);
    test_reset();
    test_word_load();
    test_byte_load();
    test_word_store_skew();
    test_byte_store_rmw();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    test_protocol();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
